// File: rtl/axa_undo_rollback_pkg.sv
// Shared constants and types for the AXA undo buffer: the entry layout and the
// rollback sequencer state encoding.
package axa_undo_rollback_pkg;

    localparam int WIDTH = 16;
    localparam int PTRW  = 4;
    localparam int DEPTH = 1 << PTRW;
    localparam int CNTW  = PTRW + 1;
    localparam int REGW  = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    typedef struct packed {
        logic [REGW-1:0]  rtag;
        logic [WIDTH-1:0] data;
    } undo_entry_t;

endpackage

// File: rtl/axa_undo_rollback_if.sv
// Bus bundle between the undo buffer and its users (decode push side, reverse-mode
// pop/peek side and the register-file writer that receives rollback entries).
interface axa_undo_rollback_if;
    import axa_undo_rollback_pkg::*;

    logic             push_valid;
    logic [WIDTH-1:0] push_data;
    logic [REGW-1:0]  push_reg;
    logic             pop_req;
    logic             pop_valid;
    logic [WIDTH-1:0] pop_data;
    logic             pop_err;
    logic [PTRW-1:0]  peek_off;
    logic [WIDTH-1:0] peek_data;
    logic             rb_start;
    logic [CNTW-1:0]  rb_count;
    logic             rst_valid;
    logic             rst_ready;
    logic [WIDTH-1:0] rst_data;
    logic [REGW-1:0]  rst_reg;
    logic             rb_done;
    logic             rb_underflow;
    logic             overflow;
    logic             busy;
    logic [CNTW-1:0]  occupancy;

    modport master (
        output push_valid, push_data, push_reg, pop_req, peek_off,
               rb_start, rb_count, rst_ready,
        input  pop_valid, pop_data, pop_err, peek_data, rst_valid, rst_data,
               rst_reg, rb_done, rb_underflow, overflow, busy, occupancy
    );

    modport slave (
        input  push_valid, push_data, push_reg, pop_req, peek_off,
               rb_start, rb_count, rst_ready,
        output pop_valid, pop_data, pop_err, peek_data, rst_valid, rst_data,
               rst_reg, rb_done, rb_underflow, overflow, busy, occupancy
    );

endinterface

// File: rtl/axa_undo_rollback_ram.sv
// Undo entry storage: one synchronous write port, two asynchronous read ports
// (peek data, and the full top-of-stack entry for pop/rollback).
module axa_undo_rollback_ram
    import axa_undo_rollback_pkg::*;
(
    input  logic             clk,
    input  logic             we,
    input  logic [PTRW-1:0]  waddr,
    input  undo_entry_t      wdata,
    input  logic [PTRW-1:0]  raddr_a,
    output logic [WIDTH-1:0] rdata_a,
    input  logic [PTRW-1:0]  raddr_b,
    output undo_entry_t      rdata_b
);

    undo_entry_t mem [DEPTH];

    // NOTE: storage has no reset; only the pointers are cleared, so reset leaves
    // saved entries in place and the array maps onto plain RAM. Sequential
    // state uses non-blocking assignment so every reader sees the pre-edge value.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_a = mem[raddr_a].data;
    assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/axa_undo_rollback.sv
// Read-back end of the AXA undo buffer: single pops, operand peeks and a rollback
// sequencer streaming saved entries to the register-file writer.
module axa_undo_rollback
    import axa_undo_rollback_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    axa_undo_rollback_if.slave bus
);

    state_e           state;
    logic [PTRW-1:0]  sp;
    logic [PTRW-1:0]  sp_dec;
    logic [PTRW-1:0]  peek_addr;
    logic [PTRW-1:0]  waddr;
    logic [CNTW-1:0]  occ;
    logic [CNTW-1:0]  remaining;
    logic             we;
    logic             is_empty;
    logic             is_full;
    logic             idle_cmd;
    logic             has_more;
    logic             take_top;
    undo_entry_t      wdata;
    undo_entry_t      top_entry;
    logic [WIDTH-1:0] peek_word;

    logic             pop_valid_q;
    logic             pop_err_q;
    logic [WIDTH-1:0] pop_data_q;
    logic             rst_valid_q;
    logic [WIDTH-1:0] rst_data_q;
    logic [REGW-1:0]  rst_reg_q;
    logic             rb_done_q;
    logic             rb_underflow_q;
    logic             overflow_q;

    assign sp_dec    = sp - PTRW'(1);
    assign peek_addr = sp - bus.peek_off - PTRW'(1);
    assign is_empty  = (occ == '0);
    assign is_full   = (occ == CNTW'(DEPTH));
    assign idle_cmd  = (state == ST_IDLE) && !bus.rb_start;
    assign has_more  = (remaining != '0) && !is_empty;
    // Entry handed to the writer: first load, or refill on an accepted handshake.
    assign take_top  = has_more && ((state == ST_LOAD) || (state == ST_DRAIN && bus.rst_ready));
    assign wdata     = {bus.push_reg, bus.push_data};

    // NOTE: every always_comb output is given a default first so that no path
    // leaves it unassigned and infers a latch.
    always_comb begin
        we    = 1'b0;
        waddr = sp;
        if (!reset && idle_cmd && bus.push_valid) begin
            if (bus.pop_req) begin
                // Push+pop replaces the top in place; on empty it is a pure bypass.
                we    = !is_empty;
                waddr = sp_dec;
            end else begin
                we = 1'b1;
            end
        end
    end

    axa_undo_rollback_ram u_ram (
        .clk     (clk),
        .we      (we),
        .waddr   (waddr),
        .wdata   (wdata),
        .raddr_a (peek_addr),
        .rdata_a (peek_word),
        .raddr_b (sp_dec),
        .rdata_b (top_entry)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_IDLE;
            sp             <= '0;
            occ            <= '0;
            remaining      <= '0;
            pop_valid_q    <= 1'b0;
            pop_err_q      <= 1'b0;
            pop_data_q     <= '0;
            rst_valid_q    <= 1'b0;
            rst_data_q     <= '0;
            rst_reg_q      <= '0;
            rb_done_q      <= 1'b0;
            rb_underflow_q <= 1'b0;
            overflow_q     <= 1'b0;
        end else begin
            pop_valid_q <= 1'b0;
            pop_err_q   <= 1'b0;
            rb_done_q   <= 1'b0;

            unique case (state)
                ST_IDLE: begin
                    if (bus.rb_start) begin
                        remaining <= bus.rb_count;
                        state     <= ST_LOAD;
                    end else if (bus.pop_req) begin
                        pop_valid_q <= 1'b1;
                        if (is_empty) begin
                            pop_data_q <= bus.push_valid ? bus.push_data : '0;
                            pop_err_q  <= !bus.push_valid;
                        end else begin
                            pop_data_q <= top_entry.data;
                            if (!bus.push_valid) begin
                                sp  <= sp_dec;
                                occ <= occ - CNTW'(1);
                            end
                        end
                    end else if (bus.push_valid) begin
                        sp <= sp + PTRW'(1);
                        if (is_full) begin
                            overflow_q <= 1'b1;
                        end else begin
                            occ <= occ + CNTW'(1);
                        end
                    end
                end
                ST_LOAD: begin
                    if (has_more) begin
                        state <= ST_DRAIN;
                    end else begin
                        if (remaining > occ) begin
                            rb_underflow_q <= 1'b1;
                        end
                        rb_done_q <= 1'b1;
                        state     <= ST_DONE;
                    end
                end
                ST_DRAIN: begin
                    if (bus.rst_ready && !has_more) begin
                        rst_valid_q <= 1'b0;
                        if (remaining != '0) begin
                            rb_underflow_q <= 1'b1;
                        end
                        rb_done_q <= 1'b1;
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
            endcase

            if (take_top) begin
                rst_valid_q <= 1'b1;
                rst_data_q  <= top_entry.data;
                rst_reg_q   <= top_entry.rtag;
                sp          <= sp_dec;
                occ         <= occ - CNTW'(1);
                remaining   <= remaining - CNTW'(1);
            end
        end
    end

    assign bus.pop_valid    = pop_valid_q;
    assign bus.pop_err      = pop_err_q;
    assign bus.pop_data     = pop_data_q;
    assign bus.peek_data    = peek_word;
    assign bus.rst_valid    = rst_valid_q;
    assign bus.rst_data     = rst_data_q;
    assign bus.rst_reg      = rst_reg_q;
    assign bus.rb_done      = rb_done_q;
    assign bus.rb_underflow = rb_underflow_q;
    assign bus.overflow     = overflow_q;
    assign bus.busy         = (state != ST_IDLE);
    assign bus.occupancy    = occ;

endmodule

// File: tb/tb_axa_undo_rollback.sv
// Self-checking bench for axa_undo_rollback: directed scenarios with literal
// expectations plus randomized traffic compared each cycle against a stack model.
module tb_axa_undo_rollback;

    logic clk;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    axa_undo_rollback_if bus ();

    axa_undo_rollback dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [15:0] m_data  [16];
    logic [3:0]  m_reg   [16];
    bit          m_known [16];
    int          m_sp, m_occ, m_n, m_idx;
    bit          m_init = 0, m_after_reset, m_over, m_under, m_under_pend;
    bit          m_busy, m_starting, m_finishing;
    logic [15:0] q_data [$];
    logic [3:0]  q_reg  [$];
    logic        exp_pop_valid, exp_pop_err, exp_rst_valid, exp_rb_done;
    logic [15:0] exp_pop_data, exp_rst_data;
    logic [3:0]  exp_rst_reg;

    initial begin
        for (int i = 0; i < 16; i++) m_known[i] = 0;
    end

    function automatic int top_idx();
        return (m_sp + 15) % 16;
    endfunction

    function void present();
        exp_rst_valid = 1;
        exp_rst_data  = q_data.pop_front();
        exp_rst_reg   = q_reg.pop_front();
        m_sp  = (m_sp + 15) % 16;
        m_occ = m_occ - 1;
    endfunction

    function void finish_rb();
        exp_rst_valid = 0;
        if (m_under_pend) m_under = 1;
        exp_rb_done = 1;
        m_finishing = 1;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_init = 1; m_after_reset = 1;
            m_sp = 0; m_occ = 0; m_over = 0; m_under = 0;
            m_busy = 0; m_starting = 0; m_finishing = 0;
            q_data.delete(); q_reg.delete();
            exp_pop_valid = 0; exp_pop_err = 0; exp_pop_data = 0;
            exp_rst_valid = 0; exp_rst_data = 0; exp_rst_reg = 0; exp_rb_done = 0;
        end else if (m_init) begin
            m_after_reset = 0;
            exp_pop_valid = 0; exp_pop_err = 0; exp_rb_done = 0;
            if (!m_busy) begin
                if (bus.rb_start) begin
                    m_n = (int'(bus.rb_count) < m_occ) ? int'(bus.rb_count) : m_occ;
                    for (int k = 0; k < m_n; k++) begin
                        m_idx = (m_sp + 32 - 1 - k) % 16;
                        q_data.push_back(m_data[m_idx]);
                        q_reg.push_back(m_reg[m_idx]);
                    end
                    m_under_pend = int'(bus.rb_count) > m_occ;
                    m_busy = 1; m_starting = 1;
                end else if (bus.pop_req && bus.push_valid) begin
                    exp_pop_valid = 1;
                    if (m_occ == 0) begin
                        exp_pop_data = bus.push_data;
                    end else begin
                        exp_pop_data = m_data[top_idx()];
                        m_data[top_idx()]  = bus.push_data;
                        m_reg[top_idx()]   = bus.push_reg;
                        m_known[top_idx()] = 1;
                    end
                end else if (bus.pop_req) begin
                    exp_pop_valid = 1;
                    if (m_occ == 0) begin
                        exp_pop_err = 1; exp_pop_data = 0;
                    end else begin
                        exp_pop_data = m_data[top_idx()];
                        m_sp = top_idx(); m_occ--;
                    end
                end else if (bus.push_valid) begin
                    m_data[m_sp] = bus.push_data; m_reg[m_sp] = bus.push_reg; m_known[m_sp] = 1;
                    m_sp = (m_sp + 1) % 16;
                    if (m_occ == 16) m_over = 1; else m_occ++;
                end
            end else if (m_starting) begin
                m_starting = 0;
                if (q_data.size() == 0) finish_rb(); else present();
            end else if (m_finishing) begin
                m_finishing = 0; m_busy = 0;
            end else if (bus.rst_ready) begin
                if (q_data.size() != 0) present(); else finish_rb();
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    int c_idx;
    always @(negedge clk) begin
        if (m_init) begin
            check("pop_valid", bus.pop_valid, exp_pop_valid);
            if (exp_pop_valid || m_after_reset) begin
                check("pop_err", bus.pop_err, exp_pop_err);
                check("pop_data", bus.pop_data, exp_pop_data);
            end
            check("rst_valid", bus.rst_valid, exp_rst_valid);
            if (exp_rst_valid || m_after_reset) begin
                check("rst_data", bus.rst_data, exp_rst_data);
                check("rst_reg", bus.rst_reg, exp_rst_reg);
            end
            check("rb_done", bus.rb_done, exp_rb_done);
            check("rb_underflow", bus.rb_underflow, m_under);
            check("overflow", bus.overflow, m_over);
            check("busy", bus.busy, m_busy);
            check("occupancy", bus.occupancy, m_occ);
            c_idx = (m_sp + 32 - int'(bus.peek_off) - 1) % 16;
            if (m_known[c_idx]) check("peek_data", bus.peek_data, m_data[c_idx]);
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1; cyc(2); reset = 0;
    endtask

    task automatic push(input logic [3:0] r, input logic [15:0] d);
        bus.push_valid = 1; bus.push_reg = r; bus.push_data = d;
        cyc();
        bus.push_valid = 0;
    endtask

    task automatic start_rb(input logic [4:0] n);
        bus.rb_start = 1; bus.rb_count = n;
        cyc();
        bus.rb_start = 0;
    endtask

    initial begin
        reset = 1;
        bus.push_valid = 0; bus.push_data = 0; bus.push_reg = 0; bus.pop_req = 0;
        bus.peek_off = 0; bus.rb_start = 0; bus.rb_count = 0; bus.rst_ready = 0;
        cyc(2);
        reset = 0;
        check("reset occupancy", bus.occupancy, 0);
        check("reset busy", bus.busy, 0);
        check("reset rst_valid", bus.rst_valid, 0);

        // Pop on empty stack.
        bus.pop_req = 1; cyc(); bus.pop_req = 0;
        check("empty pop_valid", bus.pop_valid, 1);
        check("empty pop_err", bus.pop_err, 1);
        check("empty pop_data", bus.pop_data, 0);
        check("empty occupancy", bus.occupancy, 0);

        // 17 pushes: oldest overwritten.
        for (int i = 0; i <= 16; i++) push(4'(i), 16'(i));
        check("ovf flag", bus.overflow, 1);
        check("ovf occupancy", bus.occupancy, 16);
        bus.peek_off = 4'd15; #1;
        check("peek 15", bus.peek_data, 16'd1);
        bus.peek_off = 4'd0; #1;
        check("peek 0", bus.peek_data, 16'd16);

        // Five pushes then a pop.
        do_reset();
        for (int i = 1; i <= 5; i++) push(4'(i), 16'(i * 16'h0011));
        bus.pop_req = 1; cyc(); bus.pop_req = 0;
        check("pop5 valid", bus.pop_valid, 1);
        check("pop5 data", bus.pop_data, 16'h0055);
        check("pop5 occupancy", bus.occupancy, 4);

        // Rollback of 3 with a two-cycle stall.
        do_reset();
        for (int i = 1; i <= 3; i++) push(4'(i), 16'h00A0 + 16'(i));
        bus.rst_ready = 0;
        start_rb(5'd3);
        check("rb load busy", bus.busy, 1);
        check("rb load no valid", bus.rst_valid, 0);
        cyc();
        check("rb first valid", bus.rst_valid, 1);
        check("rb first reg", bus.rst_reg, 3);
        check("rb first data", bus.rst_data, 16'h00A3);
        for (int s = 0; s < 2; s++) begin
            cyc();
            check("rb stall valid", bus.rst_valid, 1);
            check("rb stall data", bus.rst_data, 16'h00A3);
        end
        bus.rst_ready = 1; cyc();
        check("rb second reg", bus.rst_reg, 2);
        check("rb second data", bus.rst_data, 16'h00A2);
        cyc();
        check("rb third reg", bus.rst_reg, 1);
        check("rb third data", bus.rst_data, 16'h00A1);
        cyc();
        check("rb end valid", bus.rst_valid, 0);
        check("rb done pulse", bus.rb_done, 1);
        check("rb end occupancy", bus.occupancy, 0);
        cyc();
        check("rb done low", bus.rb_done, 0);
        check("rb idle", bus.busy, 0);
        check("rb no underflow", bus.rb_underflow, 0);

        // Rollback asking for more than held.
        do_reset();
        push(4'd5, 16'h0B05); push(4'd6, 16'h0B06);
        bus.rst_ready = 1;
        start_rb(5'd4);
        cyc();
        check("uf first data", bus.rst_data, 16'h0B06);
        cyc();
        check("uf second data", bus.rst_data, 16'h0B05);
        cyc();
        check("uf done pulse", bus.rb_done, 1);
        check("uf flag", bus.rb_underflow, 1);
        cyc();
        check("uf sticky", bus.rb_underflow, 1);
        check("uf done low", bus.rb_done, 0);

        // Reset in the middle of a stalled drain.
        do_reset();
        for (int i = 1; i <= 3; i++) push(4'(i), 16'h0C00 + 16'(i));
        bus.rst_ready = 0;
        start_rb(5'd3);
        cyc();
        check("mid drain valid", bus.rst_valid, 1);
        reset = 1; cyc(); reset = 0;
        check("mid reset rst_valid", bus.rst_valid, 0);
        check("mid reset rst_data", bus.rst_data, 0);
        check("mid reset busy", bus.busy, 0);
        check("mid reset occupancy", bus.occupancy, 0);
        cyc();
        check("mid reset no done", bus.rb_done, 0);

        // Push+pop on empty stack bypasses.
        bus.push_valid = 1; bus.pop_req = 1; bus.push_data = 16'hBEEF; bus.push_reg = 4'd9;
        cyc();
        bus.push_valid = 0; bus.pop_req = 0;
        check("bypass data", bus.pop_data, 16'hBEEF);
        check("bypass err", bus.pop_err, 0);
        check("bypass occupancy", bus.occupancy, 0);

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            reset          = ($urandom_range(0, 255) == 0);
            bus.push_valid = ($urandom_range(0, 9) < 4);
            bus.pop_req    = ($urandom_range(0, 9) < 3);
            bus.push_data  = 16'($urandom);
            bus.push_reg   = 4'($urandom);
            bus.peek_off   = 4'($urandom);
            bus.rb_start   = ($urandom_range(0, 19) == 0);
            bus.rb_count   = 5'($urandom_range(0, 16));
            bus.rst_ready  = ($urandom_range(0, 9) < 6);
            cyc();
        end
        reset = 0; bus.push_valid = 0; bus.pop_req = 0; bus.rb_start = 0; bus.rst_ready = 1;
        cyc(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
